prog_clk_gen: RTL
=================

Name: prog_clk_gen

Overview:
Synthesizable multi-channel clock-enable/divided-clock generator, the hardware successor to the simulation-only free-running clock model. Each channel derives a square or duty-cycled output from the single system clock, with a programmable period and high time. Each channel also provides a single-cycle rising-edge tick for downstream registers. Used by register/counter blocks that need slower strobes without extra clock domains.

Parameters:
CHANNELS, 2, number of independent output channels (1..8)
CNT_WIDTH, 8, width of period/high-time counters
DEF_PERIOD, 50, reset period in clk cycles per channel (>=2, < 2^CNT_WIDTH)
DEF_HIGH, 25, reset high time in clk cycles per channel (<= DEF_PERIOD)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous reset, active low
enable  input  CHANNELS  per-channel run enable
cfg_load  input  1  one-cycle strobe, writes cfg_period/cfg_high into the shadow regs of channel cfg_sel
cfg_sel  input  clog2(CHANNELS) (min 1)  channel select for cfg_load
cfg_period  input  CNT_WIDTH  requested period in cycles
cfg_high  input  CNT_WIDTH  requested high time in cycles
clk_out  output  CHANNELS  registered divided outputs
tick  output  CHANNELS  registered 1-cycle pulse on each clk_out 0->1 transition
cfg_pending  output  CHANNELS  shadow config written but not yet active

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clk).
- Reset, per channel: active period = DEF_PERIOD, active high = DEF_HIGH, shadows = same, cnt = DEF_PERIOD-1, clk_out=0, tick=0, cfg_pending=0.
- Per channel, each clk while enable[i]=1:
  - If cnt == P-1: cnt <= 0; shadows copy to active (P, H) if pending, and cfg_pending clears; clk_out <= (H_new > 0).
  - Else: cnt <= cnt+1; clk_out <= (cnt+1 < H).
  - tick[i] <= 1 exactly when clk_out[i] goes 0->1 in that cycle, else 0.
- Result: after a wrap, clk_out is high for H cycles, then low for P-H cycles. Latency from enable rising after reset to the clk_out/tick rise is 1 cycle.
- enable[i]=0: cnt and clk_out freeze at their current values, tick=0. Re-enable resumes mid-period without a glitch.
- cfg_load: captures the inputs into the shadow of cfg_sel and sets cfg_pending[cfg_sel]. Active values change only at the period wrap, so periods are never truncated.
  - If the channel is disabled, shadow copies to active immediately on the next clk. cnt is set to P_new-1 and clk_out is held.
- Clamping, applied at capture: cfg_period < 2 -> 2; cfg_high > period -> period.
  - H=0: clk_out constant 0, no tick.
  - H=P: clk_out constant 1; tick only on the first rise.
- cfg_sel >= CHANNELS: load ignored.
- A second cfg_load before a wrap overwrites the shadow; the last write wins.
- cfg_load on the same cycle as that channel's wrap: the old shadow is applied and the new value becomes pending.
- reset_n low mid-period: everything returns to reset values on that edge; in-flight config is discarded.

Optional Feature:
Macro PCG_SYNC_EN.
- Defined: adds input sync_in (1 bit). When sync_in=1, every enabled channel loads cnt <= P-1 and holds clk_out. All channels therefore wrap and rise together on the following cycle. sync_in takes priority over a normal wrap, and pending shadows are applied.
- Not defined: the port is absent and channels free-run independently.

Test Plan:
- Reset defaults: release reset_n, enable=2'b01 -> ch0 clk_out rises 1 cycle later with tick=1, high 25 cycles, low 25, period 50. ch1 stays 0.
- Runtime reconfig: ch0 running, cfg_load with sel=0, period=10, high=3 mid-period -> current 50-cycle period completes, cfg_pending=1 until the wrap, then 3 high / 7 low.
- Clamps: load period=1, high=0 -> period 2, output constant 0, no ticks. Load period=4, high=9 -> constant 1, one tick.
- Enable pause: deassert enable at cycle 12 of a 50-cycle period for 7 cycles -> clk_out frozen, tick=0. Resumes and completes the remaining 38 cycles.
- Reset mid-operation: reset_n low for 1 cycle with a pending config -> outputs 0, cfg_pending=0, defaults restored.
- PCG_SYNC_EN: ch0 period 6, ch1 period 9, pulse sync_in -> both rise with tick on the same cycle (2 cycles after the pulse edge).

Source files
------------

// File: rtl/prog_clk_gen.sv
// prog_clk_gen: per-channel programmable divided clock with rising-edge tick and
// wrap-synchronous shadow configuration. Define PCG_SYNC_EN to add the sync_in realign input.
module prog_clk_gen #(
  parameter int CHANNELS   = 2,
  parameter int CNT_WIDTH  = 8,
  parameter int DEF_PERIOD = 50,
  parameter int DEF_HIGH   = 25,
  localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [CHANNELS-1:0]  enable,
`ifdef PCG_SYNC_EN
  input  logic                 sync_in,
`endif
  input  logic                 cfg_load,
  input  logic [SEL_W-1:0]     cfg_sel,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_high,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  cfg_pending
);

  localparam logic [CNT_WIDTH-1:0] P_DEF   = CNT_WIDTH'(DEF_PERIOD);
  localparam logic [CNT_WIDTH-1:0] H_DEF   = CNT_WIDTH'(DEF_HIGH);
  localparam logic [CNT_WIDTH-1:0] CNT_DEF = CNT_WIDTH'(DEF_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] P_MIN   = CNT_WIDTH'(2);

  logic                 sync_act;
  logic [CNT_WIDTH-1:0] cap_p;
  logic [CNT_WIDTH-1:0] cap_h;

`ifdef PCG_SYNC_EN
  assign sync_act = sync_in;
`else
  assign sync_act = 1'b0;
`endif

  // Clamp once at capture so the active registers always hold legal values.
  always_comb begin
    cap_p = (cfg_period < P_MIN) ? P_MIN : cfg_period;
    cap_h = (cfg_high > cap_p) ? cap_p : cfg_high;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] act_p_q, act_h_q, sh_p_q, sh_h_q, cnt_q;
    logic [CNT_WIDTH-1:0] act_p_d, act_h_d, sh_p_d, sh_h_d, cnt_d;
    logic                 pend_q, out_q, tick_q;
    logic                 pend_d, out_d, tick_d;
    logic                 load_hit, wrap, apply;

    assign load_hit = cfg_load && (32'(cfg_sel) == i);
    assign wrap     = (cnt_q == (act_p_q - ONE));

    always_comb begin
      act_p_d = act_p_q;
      act_h_d = act_h_q;
      sh_p_d  = sh_p_q;
      sh_h_d  = sh_h_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      apply   = 1'b0;

      // Shadow takes effect at a wrap, on sync, or at once while the channel is idle.
      if (enable[i])
        apply = pend_q && (sync_act || wrap);
      else
        apply = pend_q;

      if (apply) begin
        act_p_d = sh_p_q;
        act_h_d = sh_h_q;
        pend_d  = 1'b0;
      end

      if (enable[i]) begin
        if (sync_act) begin
          cnt_d = act_p_d - ONE;
        end else if (wrap) begin
          cnt_d = '0;
          out_d = (act_h_d != '0);
        end else begin
          cnt_d = cnt_q + ONE;
          out_d = ((cnt_q + ONE) < act_h_q);
        end
      end else if (apply) begin
        cnt_d = act_p_d - ONE;
      end

      // A load in the same cycle as an apply lands after it, so it stays pending.
      if (load_hit) begin
        sh_p_d = cap_p;
        sh_h_d = cap_h;
        pend_d = 1'b1;
      end

      tick_d = enable[i] && out_d && !out_q;
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        act_p_q <= P_DEF;
        act_h_q <= H_DEF;
        sh_p_q  <= P_DEF;
        sh_h_q  <= H_DEF;
        cnt_q   <= CNT_DEF;
        pend_q  <= 1'b0;
        out_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        act_p_q <= act_p_d;
        act_h_q <= act_h_d;
        sh_p_q  <= sh_p_d;
        sh_h_q  <= sh_h_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        out_q   <= out_d;
        tick_q  <= tick_d;
      end
    end

    assign clk_out[i]     = out_q;
    assign tick[i]        = tick_q;
    assign cfg_pending[i] = pend_q;
  end

endmodule
